// File: rtl/video_axis_pkg.sv
// Shared types and constants for the AXI4-Stream video test-pattern generator:
// pattern codes, RGB888 colour constants and the sequencer state encoding.
package video_axis_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_LINE_GAP  = 2'd2,
    ST_FRAME_GAP = 2'd3
  } state_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;
  localparam logic [23:0] RGB_GRAY    = 24'h808080;

  // Classic eight-bar order, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = RGB_WHITE;
      3'd1:    rgb = RGB_YELLOW;
      3'd2:    rgb = RGB_CYAN;
      3'd3:    rgb = RGB_GREEN;
      3'd4:    rgb = RGB_MAGENTA;
      3'd5:    rgb = RGB_RED;
      3'd6:    rgb = RGB_BLUE;
      default: rgb = RGB_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/axis_pattern_pixel.sv
// Combinational pixel generator: maps (x, y, pattern) to an RGB888 value.
// The parent registers the result, so this block carries no state.
module axis_pattern_pixel
  import video_axis_pkg::*;
#(
  parameter int WIDTH        = 1920,
  parameter int HEIGHT       = 1080,
  parameter int DATA_WIDTH   = 24,
  parameter int COORD_WIDTH  = 16,
  parameter int GRID_SPACING = 64
) (
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  input  pattern_e               sel,
  output logic [DATA_WIDTH-1:0]  pixel
);

  localparam int BAR_W = (WIDTH >= 8) ? WIDTH / 8 : 1;
  localparam logic [COORD_WIDTH-1:0] GRID_MASK = COORD_WIDTH'(GRID_SPACING - 1);
  localparam logic [COORD_WIDTH-1:0] X_LAST    = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST    = COORD_WIDTH'(HEIGHT - 1);

  logic [COORD_WIDTH-1:0] bar_idx_full;
  logic [2:0]             bar_idx;
  logic                   on_grid;
  logic [7:0]             ramp_sum;
  logic [23:0]            rgb;

  always_comb begin
    bar_idx_full = x / COORD_WIDTH'(BAR_W);
    // Leftover columns when WIDTH is not a multiple of 8 fold into the last bar.
    bar_idx  = (bar_idx_full > COORD_WIDTH'(7)) ? 3'd7 : bar_idx_full[2:0];
    on_grid  = ((x & GRID_MASK) == '0) || ((y & GRID_MASK) == '0) ||
               (x == X_LAST) || (y == Y_LAST);
    ramp_sum = x[7:0] + y[7:0];
    rgb      = RGB_GRAY;
    case (sel)
      PAT_SOLID: rgb = RGB_GRAY;
      PAT_GRID:  rgb = on_grid ? RGB_WHITE : RGB_BLACK;
      PAT_BARS:  rgb = bar_colour(bar_idx);
      PAT_RAMP:  rgb = {x[7:0], y[7:0], ramp_sum};
      default:   rgb = RGB_GRAY;
    endcase
    pixel = DATA_WIDTH'(rgb);
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source: raster sequencer with optional
// line/frame blanking gaps, registered outputs and frame completion stats.
module axis_video_pattern_gen
  import video_axis_pkg::*;
#(
  parameter int WIDTH        = 1920,
  parameter int HEIGHT       = 1080,
  parameter int DATA_WIDTH   = 24,
  parameter int COORD_WIDTH  = 16,
  parameter int GRID_SPACING = 64,
  parameter int LINE_GAP     = 0,
  parameter int FRAME_GAP    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  busy
);

  localparam int MAX_GAP = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
  localparam int GAP_W   = (MAX_GAP > 1) ? $clog2(MAX_GAP + 1) : 1;
  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(HEIGHT - 1);
  localparam logic [GAP_W-1:0] LINE_RELOAD  = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
  localparam logic [GAP_W-1:0] FRAME_RELOAD = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  state_e                 state_q, state_d;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  pattern_e               sel_q, sel_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                   frame_done_q, frame_done_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   beat_done, load;
  logic [DATA_WIDTH-1:0]  pixel;

  // Fed with the next coordinates so a freshly loaded beat lines up with x/y.
  axis_pattern_pixel #(
    .WIDTH        (WIDTH),
    .HEIGHT       (HEIGHT),
    .DATA_WIDTH   (DATA_WIDTH),
    .COORD_WIDTH  (COORD_WIDTH),
    .GRID_SPACING (GRID_SPACING)
  ) u_pixel (
    .x     (x_d),
    .y     (y_d),
    .sel   (sel_d),
    .pixel (pixel)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    sel_d         = sel_q;
    gap_d         = gap_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    load          = 1'b0;
    beat_done     = tvalid_q && m_axis_tready;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          sel_d   = pattern_e'(pattern_sel);
        end
      end
      ST_ACTIVE: begin
        if (!tvalid_q) begin
          load = 1'b1;
        end else if (beat_done) begin
          if (x_q != X_LAST) begin
            x_d  = x_q + 1'b1;
            load = 1'b1;
          end else if (y_q != Y_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
            if (LINE_GAP == 0) begin
              load = 1'b1;
            end else begin
              state_d = ST_LINE_GAP;
              gap_d   = LINE_RELOAD;
            end
          end else begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            x_d           = '0;
            y_d           = '0;
            if (FRAME_GAP != 0) begin
              state_d = ST_FRAME_GAP;
              gap_d   = FRAME_RELOAD;
            end else if (enable) begin
              sel_d = pattern_e'(pattern_sel);
              load  = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_LINE_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_ACTIVE;
          load    = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_FRAME_GAP: begin
        if (gap_q == '0) begin
          if (enable) begin
            state_d = ST_ACTIVE;
            sel_d   = pattern_e'(pattern_sel);
            load    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The beat registers only change on load, which keeps them stable under backpressure.
    tvalid_d = tvalid_q && !beat_done;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = pixel;
      tlast_d  = (x_d == X_LAST);
      tuser_d  = (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      sel_q         <= PAT_SOLID;
      gap_q         <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      sel_q         <= sel_d;
      gap_q         <= gap_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Self-checking bench: three generator instances (8x4 no gaps, 8x4 with
// line/frame gaps, 16x4 no gaps) checked against a raster-level pixel model.
`timescale 1ns/1ps
module tb_axis_video_pattern_gen;

  localparam int N_DUT = 3;
  localparam int H     = 4;
  localparam int GS    = 4;

  typedef struct {
    logic [23:0] data;
    logic        last;
    logic        user;
    int          cyc;
  } beat_t;

  typedef struct {
    int          dut;
    int          sel;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable [N_DUT];
  logic [1:0]  sel    [N_DUT];
  logic        tready [N_DUT];
  logic [23:0] tdata  [N_DUT];
  logic        tvalid [N_DUT];
  logic        tlast  [N_DUT];
  logic        tuser  [N_DUT];
  logic        fdone  [N_DUT];
  logic [15:0] fcount [N_DUT];
  logic        busy   [N_DUT];

  beat_t       beats [N_DUT][$];
  int          fd_seen [N_DUT];
  int          exp_fc  [N_DUT];
  logic        stall_prev [N_DUT];
  logic [25:0] stall_word [N_DUT];
  logic [23:0] cap [N_DUT][4][64];
  vec_t        vecs [16];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  axis_video_pattern_gen #(.WIDTH(8), .HEIGHT(4), .GRID_SPACING(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable[0]), .pattern_sel(sel[0]),
    .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tlast(tlast[0]),
    .m_axis_tuser(tuser[0]), .m_axis_tready(tready[0]), .frame_done(fdone[0]),
    .frame_count(fcount[0]), .busy(busy[0]));

  axis_video_pattern_gen #(.WIDTH(8), .HEIGHT(4), .GRID_SPACING(4),
                           .LINE_GAP(2), .FRAME_GAP(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable[1]), .pattern_sel(sel[1]),
    .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tlast(tlast[1]),
    .m_axis_tuser(tuser[1]), .m_axis_tready(tready[1]), .frame_done(fdone[1]),
    .frame_count(fcount[1]), .busy(busy[1]));

  axis_video_pattern_gen #(.WIDTH(16), .HEIGHT(4), .GRID_SPACING(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable[2]), .pattern_sel(sel[2]),
    .m_axis_tdata(tdata[2]), .m_axis_tvalid(tvalid[2]), .m_axis_tlast(tlast[2]),
    .m_axis_tuser(tuser[2]), .m_axis_tready(tready[2]), .frame_done(fdone[2]),
    .frame_count(fcount[2]), .busy(busy[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dut_w(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  // Reference pixel computed straight from the pattern definitions.
  function automatic logic [23:0] model_pixel(input int s, input int x, input int y,
                                              input int w, input int h);
    int idx;
    case (s)
      0: return 24'h808080;
      1: return ((x % GS == 0) || (y % GS == 0) || (x == w - 1) || (y == h - 1))
                ? 24'hFFFFFF : 24'h000000;
      2: begin
        idx = x / (w / 8);
        if (idx > 7) idx = 7;
        case (idx)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      default: return {8'(x), 8'(y), 8'(x + y)};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat recorder and hold-under-backpressure checker.
  always @(negedge clk) begin
    for (int i = 0; i < N_DUT; i++) begin
      if (!rst_n) begin
        stall_prev[i] = 1'b0;
      end else begin
        if (stall_prev[i]) begin
          check($sformatf("d%0d_hold_valid", i), 64'(tvalid[i]), 64'd1);
          check($sformatf("d%0d_hold_beat", i), 64'({tdata[i], tlast[i], tuser[i]}),
                64'(stall_word[i]));
        end
        if (fdone[i]) fd_seen[i]++;
        if (tvalid[i] && tready[i])
          beats[i].push_back('{data: tdata[i], last: tlast[i], user: tuser[i], cyc: cyc});
        stall_prev[i] = tvalid[i] && !tready[i];
        stall_word[i] = {tdata[i], tlast[i], tuser[i]};
      end
    end
  end

  task automatic start_frame(input int i, input logic [1:0] s, input bit keep_enable);
    int k;
    sel[i]    = s;
    enable[i] = 1'b1;
    k = 0;
    while (!busy[i] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("d%0d_start_busy", i), 64'(busy[i]), 64'd1);
    check($sformatf("d%0d_latency_tvalid_low", i), 64'(tvalid[i]), 64'd0);
    @(posedge clk); #1;
    check($sformatf("d%0d_first_beat_valid", i), 64'({tvalid[i], tuser[i]}), 64'd3);
    if (!keep_enable) enable[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int k;
    k = 0;
    while (busy[i] && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("d%0d_idle_timeout", i), 64'(busy[i]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int i, input int n);
    int k;
    k = 0;
    while (beats[i].size() < n && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("d%0d_beats_reached_%0d", i, n), 64'(beats[i].size() >= n), 64'd1);
  endtask

  task automatic check_frame(input int i, input int s, input int base);
    int w;
    int x;
    int y;
    beat_t b;
    w = dut_w(i);
    check($sformatf("d%0d_frame_beats_present", i), 64'(beats[i].size() >= base + w * H), 64'd1);
    for (int k = 0; k < w * H && base + k < beats[i].size(); k++) begin
      x = k % w;
      y = k / w;
      b = beats[i][base + k];
      check($sformatf("d%0d_pix(%0d,%0d)_data", i, x, y), 64'(b.data),
            64'(model_pixel(s, x, y, w, H)));
      check($sformatf("d%0d_pix(%0d,%0d)_last", i, x, y), 64'(b.last), 64'(x == w - 1));
      check($sformatf("d%0d_pix(%0d,%0d)_user", i, x, y), 64'(b.user), 64'(k == 0));
      cap[i][s][k] = b.data;
    end
  endtask

  task automatic check_idle_outputs(input int i, input string tag);
    check($sformatf("d%0d_%s_tvalid", i, tag), 64'(tvalid[i]), 64'd0);
    check($sformatf("d%0d_%s_busy", i, tag), 64'(busy[i]), 64'd0);
    check($sformatf("d%0d_%s_frame_count", i, tag), 64'(fcount[i]), 64'(exp_fc[i]));
  endtask

  task automatic check_reset_outputs(input int i, input string tag);
    check($sformatf("d%0d_%s_tvalid", i, tag), 64'(tvalid[i]), 64'd0);
    check($sformatf("d%0d_%s_tlast", i, tag), 64'(tlast[i]), 64'd0);
    check($sformatf("d%0d_%s_tuser", i, tag), 64'(tuser[i]), 64'd0);
    check($sformatf("d%0d_%s_tdata", i, tag), 64'(tdata[i]), 64'd0);
    check($sformatf("d%0d_%s_frame_done", i, tag), 64'(fdone[i]), 64'd0);
    check($sformatf("d%0d_%s_busy", i, tag), 64'(busy[i]), 64'd0);
    check($sformatf("d%0d_%s_frame_count", i, tag), 64'(fcount[i]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    int stall;
    int k;
    int s;

    vecs = '{
      '{0, 1, 0, 0, 24'hFFFFFF}, '{0, 1, 1, 1, 24'h000000}, '{0, 1, 4, 1, 24'hFFFFFF},
      '{0, 1, 7, 2, 24'hFFFFFF}, '{0, 1, 3, 3, 24'hFFFFFF}, '{0, 1, 2, 2, 24'h000000},
      '{2, 2, 0, 0, 24'hFFFFFF}, '{2, 2, 1, 0, 24'hFFFFFF}, '{2, 2, 2, 1, 24'hFFFF00},
      '{2, 2, 3, 3, 24'hFFFF00}, '{2, 2, 14, 0, 24'h000000}, '{2, 2, 15, 2, 24'h000000},
      '{2, 2, 5, 0, 24'h00FFFF}, '{2, 2, 11, 1, 24'hFF0000}, '{0, 3, 3, 2, 24'h030205},
      '{0, 0, 5, 1, 24'h808080}
    };
    for (int i = 0; i < N_DUT; i++) begin
      enable[i] = 1'b0;
      sel[i]    = 2'd0;
      tready[i] = 1'b1;
      fd_seen[i] = 0;
      exp_fc[i]  = 0;
      stall_prev[i] = 1'b0;
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 64; b++) cap[i][a][b] = 24'hDEADBE;
    end

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N_DUT; i++) check_reset_outputs(i, "por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single grid frame.
    beats[0].delete();
    fd0 = fd_seen[0];
    start_frame(0, 2'd1, 1'b0);
    wait_idle(0);
    exp_fc[0]++;
    check("d0_grid_beat_total", 64'(beats[0].size()), 64'd32);
    check_frame(0, 1, 0);
    check("d0_grid_frame_done_pulses", 64'(fd_seen[0] - fd0), 64'd1);
    check_idle_outputs(0, "grid_end");

    // Ramp frame with a 5-cycle stall while pixel (3,0) is presented; sel toggles mid-frame.
    beats[0].delete();
    start_frame(0, 2'd3, 1'b0);
    stall = 0;
    k = 0;
    while (busy[0] && k < 500) begin
      @(posedge clk); #1;
      if (beats[0].size() == 3 && stall < 5) begin
        tready[0] = 1'b0;
        stall++;
      end else begin
        tready[0] = 1'b1;
      end
      sel[0] = 2'($urandom);
      k++;
    end
    tready[0] = 1'b1;
    wait_idle(0);
    exp_fc[0]++;
    check("d0_stall_cycles", 64'(stall), 64'd5);
    check("d0_stall_beat_total", 64'(beats[0].size()), 64'd32);
    check_frame(0, 3, 0);
    check_idle_outputs(0, "stall_end");

    // enable dropped after beat 10: frame still completes, then idle.
    beats[0].delete();
    start_frame(0, 2'd0, 1'b1);
    wait_beats(0, 10);
    enable[0] = 1'b0;
    wait_idle(0);
    exp_fc[0]++;
    check("d0_noTrunc_beat_total", 64'(beats[0].size()), 64'd32);
    check_frame(0, 0, 0);
    check_idle_outputs(0, "noTrunc_end");

    // Back-to-back frames with no frame gap.
    beats[0].delete();
    fd0 = fd_seen[0];
    start_frame(0, 2'd1, 1'b1);
    wait_beats(0, 33);
    enable[0] = 1'b0;
    wait_idle(0);
    exp_fc[0] += 2;
    check("d0_b2b_beat_total", 64'(beats[0].size()), 64'd64);
    check_frame(0, 1, 0);
    check_frame(0, 1, 32);
    if (beats[0].size() >= 33)
      check("d0_b2b_spacing", 64'(beats[0][32].cyc - beats[0][31].cyc), 64'd1);
    check("d0_b2b_frame_done_pulses", 64'(fd_seen[0] - fd0), 64'd2);
    check_idle_outputs(0, "b2b_end");

    // Line gap 2 / frame gap 3 spacing across two frames.
    beats[1].delete();
    start_frame(1, 2'd1, 1'b1);
    wait_beats(1, 33);
    enable[1] = 1'b0;
    wait_idle(1);
    exp_fc[1] += 2;
    check("d1_gap_beat_total", 64'(beats[1].size()), 64'd64);
    check_frame(1, 1, 0);
    check_frame(1, 1, 32);
    for (int b = 1; b < 64 && b < beats[1].size(); b++)
      check($sformatf("d1_spacing_beat%0d", b), 64'(beats[1][b].cyc - beats[1][b - 1].cyc),
            (b == 32) ? 64'd4 : (b % 8 == 0) ? 64'd3 : 64'd1);
    check_idle_outputs(1, "gap_end");

    // Colour bars on the 16-wide instance.
    beats[2].delete();
    start_frame(2, 2'd2, 1'b0);
    wait_idle(2);
    exp_fc[2]++;
    check_frame(2, 2, 0);
    check_idle_outputs(2, "bars_end");

    // Randomised frames: random pattern, random backpressure, sel churn mid-frame.
    for (int r = 0; r < 6; r++) begin
      int i;
      i = r % N_DUT;
      s = int'($urandom_range(0, 3));
      beats[i].delete();
      start_frame(i, 2'(s), 1'b0);
      k = 0;
      while (busy[i] && k < 3000) begin
        @(posedge clk); #1;
        tready[i] = ($urandom_range(0, 3) != 0);
        sel[i] = 2'($urandom);
        k++;
      end
      tready[i] = 1'b1;
      wait_idle(i);
      exp_fc[i]++;
      check($sformatf("d%0d_rand%0d_beat_total", i, r), 64'(beats[i].size()), 64'(dut_w(i) * H));
      check_frame(i, s, 0);
      check_idle_outputs(i, "rand_end");
    end

    // Reset in the middle of a frame.
    beats[0].delete();
    start_frame(0, 2'd3, 1'b0);
    wait_beats(0, 12);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "midreset");
    for (int i = 0; i < N_DUT; i++) exp_fc[i] = 0;
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    beats[0].delete();
    start_frame(0, 2'd1, 1'b0);
    wait_beats(0, 1);
    check("d0_after_reset_frame_count", 64'(fcount[0]), 64'd0);
    wait_idle(0);
    exp_fc[0]++;
    check_frame(0, 1, 0);
    check_idle_outputs(0, "after_reset_end");

    // Hand-picked pixel values from captured frames.
    for (int v = 0; v < 16; v++)
      check($sformatf("vec%0d_d%0d_sel%0d_(%0d,%0d)", v, vecs[v].dut, vecs[v].sel, vecs[v].x, vecs[v].y),
            64'(cap[vecs[v].dut][vecs[v].sel][vecs[v].y * dut_w(vecs[v].dut) + vecs[v].x]),
            64'(vecs[v].exp));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_video_pattern_gen.md
AXIS_VIDEO_PATTERN_GEN -- requirements
Module: axis_video_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 1920, active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 1080, active lines per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 24, RGB888 pixel width.
REQ-004 SHALL have parameter COORD_WIDTH, default 16, x/y counter width.
REQ-005 SHALL have parameter GRID_SPACING, default 64, grid pitch in pixels (power of two).
REQ-006 SHALL have parameter LINE_GAP, default 0, idle cycles after each non-final line.
REQ-007 SHALL have parameter FRAME_GAP, default 0, idle cycles after each frame.
REQ-008 SHALL have port clk  in  1  clock, all logic rising-edge.
REQ-009 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-010 SHALL have port enable  in  1  run request, sampled at frame boundaries.
REQ-011 SHALL have port pattern_sel  in  2  0 solid gray, 1 grid, 2 colour bars, 3 ramp.
REQ-012 SHALL have port m_axis_tdata  out  DATA_WIDTH  pixel.
REQ-013 SHALL have port m_axis_tvalid  out  1  beat valid.
REQ-014 SHALL have port m_axis_tlast  out  1  last pixel of line.
REQ-015 SHALL have port m_axis_tuser  out  1  first pixel of frame.
REQ-016 SHALL have port m_axis_tready  in  1  downstream ready.
REQ-017 SHALL have port frame_done  out  1  one-cycle pulse per completed frame.
REQ-018 SHALL have port frame_count  out  16  completed frames, wraps 0xFFFF->0.
REQ-019 SHALL have port busy  out  1  high in any state except IDLE.

Function
REQ-020 SHALL implement states IDLE, ACTIVE, LINE_GAP, FRAME_GAP.
REQ-021 IDLE->ACTIVE when enable=1; x=y=0, pattern_sel latched; tvalid rises on the following edge (1-cycle latency).
REQ-022 Beat transfers only when tvalid&&tready; tdata/tlast/tuser SHALL hold stable while tvalid&&!tready.
REQ-023 tuser=1 only on (0,0); tlast=1 only at x=WIDTH-1.
REQ-024 On tlast transfer with y<HEIGHT-1: x=0, y+1; enter LINE_GAP for LINE_GAP cycles (tvalid=0), skip if 0.
REQ-025 On final pixel transfer (WIDTH-1,HEIGHT-1): frame_done pulses next cycle, frame_count+1, enter FRAME_GAP for FRAME_GAP cycles (skip if 0).
REQ-026 After frame end: enable=1 -> new frame, pattern_sel re-latched, back-to-back when FRAME_GAP=0; else IDLE.
REQ-027 enable deasserted mid-frame SHALL NOT truncate; current frame completes.
REQ-028 pattern_sel changes mid-frame SHALL be ignored.
REQ-029 Solid: 0x808080.
REQ-030 Grid: 0xFFFFFF when x%GRID_SPACING==0, y%GRID_SPACING==0, x==WIDTH-1 or y==HEIGHT-1; else 0x000000.
REQ-031 Bars: index x/(WIDTH/8) -> FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; index clamped to 7.
REQ-032 Ramp: {x[7:0], y[7:0], (x+y)[7:0]}.
REQ-033 Gap counters SHALL be wide enough for max(LINE_GAP,FRAME_GAP); no arithmetic overflow on x/y.

Reset
REQ-034 rst_n low SHALL force IDLE, x=y=0, tvalid/tlast/tuser/frame_done/busy=0, tdata=0, frame_count=0, immediately.
REQ-035 Reset mid-frame SHALL abandon the frame; next frame starts at (0,0) with tuser=1.

Structure
REQ-036 Package video_axis_pkg SHALL hold pattern codes, colour constants, state encoding.
REQ-037 Sub-module axis_pattern_pixel SHALL compute the pixel combinationally from x, y, latched sel; output registered in parent.

Verification (WIDTH=8, HEIGHT=4, GRID_SPACING=4 unless stated)
REQ-038 Grid, tready=1, enable=1: beat0 tuser=1 tdata=FFFFFF; (1,1)=000000; (4,1)=FFFFFF; tlast on beats 8,16,24,32; frame_done once; frame_count=1.
REQ-039 tready=0 for 5 cycles at (3,0): tdata held, 32 beats total, no skipped or repeated pixel.
REQ-040 enable=0 after beat 10: all 32 beats delivered, then tvalid=0, busy=0.
REQ-041 LINE_GAP=2, FRAME_GAP=3: tvalid low exactly 2 cycles after beats 8,16,24 and 3 cycles before next tuser.
REQ-042 rst_n pulsed at beat 12: outputs 0 asynchronously; after release+enable, first beat tuser=1 at (0,0), frame_count=0.
REQ-043 Bars, WIDTH=16: x=0..1 FFFFFF, x=2..3 FFFF00, x=14..15 000000; ramp (3,2)=0x030205.
